// File: rtl/gshare_predictor_if.sv
// Bundle between the fetch/execute pipeline and the gshare predictor:
// IF lookup request and prediction result, plus the EX resolution feedback.
`ifndef GSHARE_GHSR_WIDTH
`define GSHARE_GHSR_WIDTH 8
`endif

interface gshare_predictor_if #(
    parameter int GHSR_W = `GSHARE_GHSR_WIDTH
);
    logic [31:0]       if_pc;
    logic              if_valid;
    logic              pred_taken;
    logic              pred_btb_hit;
    logic [31:0]       pred_target;
    logic [31:0]       pred_next_pc;
    logic [GHSR_W-1:0] pred_ghsr;
    logic              ex_is_bj;
    logic [31:0]       ex_pc;
    logic [GHSR_W-1:0] ex_ghsr;
    logic              ex_branch_taken;
    logic [31:0]       ex_branch_target_pc;
    logic              ex_flush;
    logic              ex_update_ghsr;
    logic [GHSR_W-1:0] ex_ghsr_restore;

    modport master (
        output if_pc, if_valid,
        output ex_is_bj, ex_pc, ex_ghsr, ex_branch_taken, ex_branch_target_pc,
        output ex_flush, ex_update_ghsr, ex_ghsr_restore,
        input  pred_taken, pred_btb_hit, pred_target, pred_next_pc, pred_ghsr
    );

    modport slave (
        input  if_pc, if_valid,
        input  ex_is_bj, ex_pc, ex_ghsr, ex_branch_taken, ex_branch_target_pc,
        input  ex_flush, ex_update_ghsr, ex_ghsr_restore,
        output pred_taken, pred_btb_hit, pred_target, pred_next_pc, pred_ghsr
    );
endinterface

// File: rtl/gshare_predictor.sv
// IF-stage gshare direction predictor (global history XOR PC into 2-bit
// counters) with a direct-mapped BTB; trained by EX-stage resolutions.
`ifndef GSHARE_GHSR_WIDTH
`define GSHARE_GHSR_WIDTH 8
`endif

module gshare_predictor #(
    parameter int GHSR_W    = `GSHARE_GHSR_WIDTH,
    parameter int BTB_IDX_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    gshare_predictor_if.slave   bp_io
);
    localparam int PHT_N = 1 << GHSR_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 32 - BTB_IDX_W - 2;

    function automatic logic [1:0] pht_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'd3) res = ctr + 2'd1;
            else             res = ctr;
        end else begin
            if (ctr != 2'd0) res = ctr - 2'd1;
            else             res = ctr;
        end
        return res;
    endfunction

    logic [GHSR_W-1:0]    ghsr_q, ghsr_d;
    logic [1:0]           pht_q [PHT_N];
    logic [BTB_N-1:0]     btb_valid_q;
    logic [TAG_W-1:0]     btb_tag_q [BTB_N];
    logic [31:0]          btb_tgt_q [BTB_N];

    logic [BTB_IDX_W-1:0] if_btb_idx_s, ex_btb_idx_s;
    logic [TAG_W-1:0]     if_tag_s, ex_tag_s;
    logic [GHSR_W-1:0]    if_pht_idx_s, ex_pht_idx_s;
    logic                 hit_s, taken_s, btb_wr_s;
    logic [1:0]           pht_upd_s;

    assign if_btb_idx_s = bp_io.if_pc[BTB_IDX_W+1:2];
    assign if_tag_s     = bp_io.if_pc[31:BTB_IDX_W+2];
    assign if_pht_idx_s = bp_io.if_pc[GHSR_W+1:2] ^ ghsr_q;
    assign ex_btb_idx_s = bp_io.ex_pc[BTB_IDX_W+1:2];
    assign ex_tag_s     = bp_io.ex_pc[31:BTB_IDX_W+2];
    assign ex_pht_idx_s = bp_io.ex_pc[GHSR_W+1:2] ^ bp_io.ex_ghsr;
    assign btb_wr_s     = bp_io.ex_is_bj && bp_io.ex_branch_taken;
    assign pht_upd_s    = pht_next(pht_q[ex_pht_idx_s], bp_io.ex_branch_taken);

    // Outputs are forced to their idle values while reset is held.
    assign hit_s   = reset_n && btb_valid_q[if_btb_idx_s] && (btb_tag_q[if_btb_idx_s] == if_tag_s);
    assign taken_s = hit_s && pht_q[if_pht_idx_s][1];

    assign bp_io.pred_btb_hit = hit_s;
    assign bp_io.pred_taken   = taken_s;
    assign bp_io.pred_target  = hit_s ? btb_tgt_q[if_btb_idx_s] : 32'd0;
    assign bp_io.pred_next_pc = taken_s ? btb_tgt_q[if_btb_idx_s] : (bp_io.if_pc + 32'd4);
    assign bp_io.pred_ghsr    = reset_n ? ghsr_q : {GHSR_W{1'b0}};

    // History next state: EX repair overrides the speculative IF shift.
    always_comb begin
        ghsr_d = ghsr_q;
        if (bp_io.ex_flush || bp_io.ex_update_ghsr) begin
            ghsr_d = {bp_io.ex_ghsr_restore[GHSR_W-2:0], bp_io.ex_branch_taken};
        end else if (bp_io.if_valid && hit_s) begin
            ghsr_d = {ghsr_q[GHSR_W-2:0], taken_s};
        end else begin
            ghsr_d = ghsr_q;
        end
    end

    // History register.
    always_ff @(posedge clk) begin
        if (!reset_n) ghsr_q <= {GHSR_W{1'b0}};
        else          ghsr_q <= ghsr_d;
    end

    // Pattern history table: all counters reset to weakly not-taken.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'd1;
        end else if (bp_io.ex_is_bj) begin
            pht_q[ex_pht_idx_s] <= pht_upd_s;
        end
    end

    // BTB valid bits: only taken resolutions allocate, nothing invalidates.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btb_valid_q <= {BTB_N{1'b0}};
        end else if (btb_wr_s) begin
            btb_valid_q[ex_btb_idx_s] <= 1'b1;
        end
    end

    // BTB tag/target payload, qualified by the valid bits above.
    always_ff @(posedge clk) begin
        if (reset_n && btb_wr_s) begin
            btb_tag_q[ex_btb_idx_s] <= ex_tag_s;
            btb_tgt_q[ex_btb_idx_s] <= bp_io.ex_branch_target_pc;
        end
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// Table-driven bench for gshare_predictor with a scoreboard queue of
// expected lookup results, compared on the falling clock edge.
module tb_gshare_predictor;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    gshare_predictor_if #(.GHSR_W(8)) bp ();

    gshare_predictor #(.GHSR_W(8), .BTB_IDX_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bp_io   (bp)
    );

    typedef struct {
        logic        rst_n;
        logic [31:0] if_pc;
        logic        if_valid;
        logic        is_bj;
        logic [31:0] ex_pc;
        logic [7:0]  ex_ghsr;
        logic        ex_tk;
        logic [31:0] ex_tgt;
        logic        flush;
        logic        upd;
        logic [7:0]  restore;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic [7:0]  e_ghsr;
    } vec_t;

    typedef struct {
        int          id;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic [31:0] e_next;
        logic [7:0]  e_ghsr;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[21];
    int   total = 0;
    int   bad   = 0;
    int   step_id = 0;

    function automatic vec_t mk(input logic r, input logic [31:0] pc, input logic v,
                                input logic bj, input logic [31:0] xpc, input logic [7:0] xg,
                                input logic xt, input logic [31:0] xtg, input logic fl,
                                input logic up, input logic [7:0] rs, input logic eh,
                                input logic et, input logic [31:0] etg, input logic [7:0] eg);
        vec_t t;
        t.rst_n = r;  t.if_pc = pc;   t.if_valid = v;
        t.is_bj = bj; t.ex_pc = xpc;  t.ex_ghsr = xg;  t.ex_tk = xt; t.ex_tgt = xtg;
        t.flush = fl; t.upd = up;     t.restore = rs;
        t.e_hit = eh; t.e_tk = et;    t.e_tgt = etg;   t.e_ghsr = eg;
        return t;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, id, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n                = v.rst_n;
        bp.if_pc               = v.if_pc;
        bp.if_valid            = v.if_valid;
        bp.ex_is_bj            = v.is_bj;
        bp.ex_pc               = v.ex_pc;
        bp.ex_ghsr             = v.ex_ghsr;
        bp.ex_branch_taken     = v.ex_tk;
        bp.ex_branch_target_pc = v.ex_tgt;
        bp.ex_flush            = v.flush;
        bp.ex_update_ghsr      = v.upd;
        bp.ex_ghsr_restore     = v.restore;
        e.id     = step_id;
        e.e_hit  = v.e_hit;
        e.e_tk   = v.e_tk;
        e.e_tgt  = v.e_tgt;
        e.e_next = v.e_tk ? v.e_tgt : (v.if_pc + 32'd4);
        e.e_ghsr = v.e_ghsr;
        sb.push_back(e);
        step_id++;
    endtask

    // Compare the combinational prediction mid-cycle, before the next edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pred_btb_hit", e.id, {31'd0, bp.pred_btb_hit}, {31'd0, e.e_hit});
            chk("pred_taken",   e.id, {31'd0, bp.pred_taken},   {31'd0, e.e_tk});
            chk("pred_target",  e.id, bp.pred_target,           e.e_tgt);
            chk("pred_next_pc", e.id, bp.pred_next_pc,          e.e_next);
            chk("pred_ghsr",    e.id, {24'd0, bp.pred_ghsr},    {24'd0, e.e_ghsr});
        end
    end

    initial begin
        reset_n = 1'b0;
        bp.if_pc = 32'h0; bp.if_valid = 1'b0; bp.ex_is_bj = 1'b0; bp.ex_pc = 32'h0;
        bp.ex_ghsr = 8'h00; bp.ex_branch_taken = 1'b0; bp.ex_branch_target_pc = 32'h0;
        bp.ex_flush = 1'b0; bp.ex_update_ghsr = 1'b0; bp.ex_ghsr_restore = 8'h00;

        // Reset, cold train, saturation (counter at PHT index 0x40)
        tbl[0]  = mk(1'b0, 32'h100, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,   8'h00);
        tbl[1]  = mk(1'b0, 32'h100, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,   8'h00);
        tbl[2]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,   8'h00);
        tbl[3]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 8'h00, 1'b1, 32'h180, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,   8'h00);
        tbl[4]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 8'h00, 1'b1, 32'h180, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h180, 8'h00);
        tbl[5]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 8'h00, 1'b1, 32'h180, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h180, 8'h00);
        tbl[6]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 8'h00, 1'b1, 32'h180, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h180, 8'h00);
        tbl[7]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h180, 8'h00);
        tbl[8]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h180, 8'h00);
        tbl[9]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h180, 8'h00);
        tbl[10] = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h180, 8'h00);
        tbl[11] = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 8'h00, 1'b1, 32'h180, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h180, 8'h00);
        tbl[12] = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 8'h00, 1'b1, 32'h180, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h180, 8'h00);
        tbl[13] = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h180, 8'h00);
        // Alias at BTB index 0, then EX events with ex_is_bj low
        tbl[14] = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h140, 8'h00, 1'b1, 32'h200, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h180, 8'h00);
        tbl[15] = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,   8'h00);
        tbl[16] = mk(1'b1, 32'h140, 1'b0, 1'b1, 32'h140, 8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h200, 8'h00);
        tbl[17] = mk(1'b1, 32'h140, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h200, 8'h00);
        tbl[18] = mk(1'b1, 32'h140, 1'b0, 1'b0, 32'h180, 8'h00, 1'b1, 32'h300, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h200, 8'h00);
        tbl[19] = mk(1'b1, 32'h180, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0,   8'h01);
        tbl[20] = mk(1'b1, 32'h140, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h200, 8'h00);

        for (int i = 0; i < 21; i++) step(tbl[i]);

        // History priority: restore to 0x0F, train index 0x4F, then flush vs. shift
        step(mk(1'b1, 32'h140, 1'b0, 1'b1, 32'h100, 8'h0F, 1'b1, 32'h180, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 32'h200, 8'h00));
        step(mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 8'h0F, 1'b1, 32'h180, 1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 32'h180, 8'h0F));
        step(mk(1'b1, 32'h100, 1'b1, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b1, 1'b0, 8'h81, 1'b1, 1'b1, 32'h180, 8'h0F));
        step(mk(1'b1, 32'h100, 1'b1, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h180, 8'h02));
        step(mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h180, 8'h04));

        // Reset mid-operation with a concurrent EX update that must be dropped
        step(mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   8'h00, 1'b1, 32'h0,   1'b0, 1'b1, 8'h52, 1'b1, 1'b0, 32'h180, 8'h04));
        step(mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h180, 8'hA5));
        step(mk(1'b0, 32'h100, 1'b0, 1'b1, 32'h100, 8'h00, 1'b1, 32'h180, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,   8'h00));
        step(mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,   8'h00));
        step(mk(1'b1, 32'h140, 1'b0, 1'b1, 32'h100, 8'h01, 1'b1, 32'h180, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,   8'h00));
        step(mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h180, 8'h00));

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 4 && sb.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

IF-stage gshare direction predictor with a direct-mapped branch target buffer. It is the producer of the `branch_predict` bundle that travels with each instruction to the EX-stage branch/jump unit, and the consumer of that unit's resolution outputs: `flush`, `update_GHSR`, `GHSR_restore`, `branch_taken` and `branch_target_pc`. It holds the speculative global history register (GHSR), a pattern history table (PHT) of 2-bit saturating counters, and the BTB.

## Interface
Parameters:
- GHSR_W, default GSHARE_GHSR_WIDTH (8): history width; the PHT has 2^GHSR_W entries.
- BTB_IDX_W, default 4: the BTB has 2^BTB_IDX_W entries; index is pc[BTB_IDX_W+1:2], tag is pc[31:BTB_IDX_W+2].

Ports. Clock, reset, IF side:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- if_pc  in  32  fetch PC.
- if_valid  in  1  fetch advances this cycle (not stalled).
- pred_taken  out  1  predicted direction.
- pred_btb_hit  out  1  BTB valid and tag match.
- pred_target  out  32  BTB target on hit, otherwise 0.
- pred_next_pc  out  32  pred_target if pred_taken, else if_pc+4.
- pred_ghsr  out  GHSR_W  GHSR used for this prediction.

EX side:
- ex_is_bj  in  1  resolving instruction is a branch, jal or jalr.
- ex_pc  in  32  PC of the resolving instruction.
- ex_ghsr  in  GHSR_W  pred_ghsr carried with that instruction.
- ex_branch_taken  in  1  resolved direction.
- ex_branch_target_pc  in  32  resolved target.
- ex_flush  in  1  misprediction flush.
- ex_update_ghsr  in  1  history must be repaired.
- ex_ghsr_restore  in  GHSR_W  architectural history, excluding the current outcome.

## Operation
Prediction is combinational from if_pc and registered state.
- pht_idx = if_pc[GHSR_W+1:2] ^ ghsr.
- pred_btb_hit = btb_valid[idx] && btb_tag[idx] == tag.
- pred_taken = pred_btb_hit && pht[pht_idx][1]. A BTB miss always predicts not-taken.
- pred_ghsr = ghsr.

GHSR next-state, in priority order:
1. !reset_n: ghsr = 0.
2. ex_flush || ex_update_ghsr: ghsr = {ex_ghsr_restore[GHSR_W-2:0], ex_branch_taken}. Any IF speculative shift in the same cycle is discarded.
3. if_valid && pred_btb_hit: ghsr = {ghsr[GHSR_W-2:0], pred_taken}.
4. Otherwise hold.

PHT update on ex_is_bj:
- Index is ex_pc[GHSR_W+1:2] ^ ex_ghsr.
- Counter +1 if ex_branch_taken, else -1.
- Saturates at 3 and at 0.
- Encoding: 0 strongly NT, 1 weakly NT, 2 weakly T, 3 strongly T.

BTB update on ex_is_bj && ex_branch_taken:
- Write valid=1, tag=ex_pc[31:BTB_IDX_W+2], target=ex_branch_target_pc at index ex_pc[BTB_IDX_W+1:2].
- This replaces any aliasing entry.
- A not-taken resolution never allocates and never invalidates.

Reset clears all BTB valid bits and sets all PHT counters to 1 (weakly NT), both in a single cycle.

## Timing
- Prediction latency is 0 cycles (same-cycle combinational lookup). All state updates are visible from the cycle after the clock edge.
- Read-during-write: an IF lookup in the same cycle as an EX write to the same BTB or PHT entry returns the old contents.
- Output values during reset:
  - pred_btb_hit = 0, pred_taken = 0, pred_target = 0, pred_ghsr = 0, pred_next_pc = if_pc+4.
  - These hold until the first post-reset allocation.
- Reset asserted mid-operation: all state returns to the reset values at that edge, and any concurrent EX update is dropped.
- ex_is_bj=0 blocks all PHT and BTB writes, even if ex_flush is high.
- if_valid=0 blocks the speculative GHSR shift. Lookup outputs remain valid.

## Test plan
Configuration for all scenarios: GHSR_W=8, BTB_IDX_W=4.
- **Reset:** after reset, if_pc=0x100 -> pred_btb_hit=0, pred_taken=0, pred_next_pc=0x104, pred_ghsr=0x00.
- **Cold train:** EX resolves ex_pc=0x100, ex_ghsr=0, taken, target 0x180. Next cycle if_pc=0x100 -> hit=1, target=0x180, counter[0x40]=2, pred_taken=1, pred_next_pc=0x180.
- **Saturation:**
  - Four taken resolutions at the same index -> counter=3.
  - Then one not-taken -> 2, pred_taken still 1.
  - Then three more not-taken -> 0, never wraps.
- **Alias:**
  - BTB holds 0x100 -> 0x180.
  - Taken resolution of ex_pc=0x140 (same index 0, tag 5) with target 0x200 -> lookup of 0x100 misses; lookup of 0x140 hits with target 0x200.
  - A not-taken resolution of 0x140 leaves the entry intact.
- **GHSR priority:**
  - Starting state: ghsr=0x0F; if_valid=1 with a hit predicted taken.
  - Same cycle: ex_flush=1, ex_ghsr_restore=0x81, ex_branch_taken=0 -> next ghsr=0x02, not 0x1F.
  - The next cycle without EX events shifts normally.
- **Reset mid-operation:** with a trained BTB and ghsr=0xA5, assert reset_n=0 for one cycle while ex_is_bj=1 -> ghsr=0, all lookups miss, and no counter is changed by the dropped update.
